// File: rtl/frame_sequencer_pkg.sv
// Shared configuration, state encoding and output payload for the frame sequencer.
package frame_sequencer_pkg;

    localparam int unsigned PIXEL_ARRAY_HEIGHT = 2;
    localparam int unsigned PIXEL_BITS         = 8;

    localparam int unsigned ROWS         = PIXEL_ARRAY_HEIGHT;
    localparam int unsigned RAMP_BITS    = PIXEL_BITS;
    localparam int unsigned ERASE_CYCLES = 5;
    localparam int unsigned EXPOSE_W     = 16;
    // A single-row array still needs a 1-bit index port.
    localparam int unsigned ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_SETTLE,
        S_READ,
        S_DONE
    } seq_state_t;

    // Every registered sequencer output in one word.
    typedef struct packed {
        logic                 pixel_erase;
        logic                 pixel_expose;
        logic                 pixel_analog_ramp;
        logic [RAMP_BITS-1:0] pixel_digital_ramp;
        logic [ROWS-1:0]      row_select;
        logic [ROW_W-1:0]     row_index;
        logic                 row_valid;
        logic                 busy;
        logic                 frame_finished;
    } seq_out_t;

    // One-hot row select from a binary row index.
    function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
        return ROWS'(1) << idx;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control inputs, pixel-array drives and row handshake of the frame sequencer.
interface frame_sequencer_if;
    import frame_sequencer_pkg::*;

    logic                 start;
    logic                 continuous;
    logic [EXPOSE_W-1:0]  expose_cycles;
    logic                 abort;
    logic                 pixel_erase;
    logic                 pixel_expose;
    logic                 pixel_analog_ramp;
    logic [RAMP_BITS-1:0] pixel_digital_ramp;
    logic [ROWS-1:0]      row_select;
    logic [ROW_W-1:0]     row_index;
    logic                 row_valid;
    logic                 row_ready;
    logic                 busy;
    logic                 frame_finished;

    modport master (
        input  start, continuous, expose_cycles, abort, row_ready,
        output pixel_erase, pixel_expose, pixel_analog_ramp, pixel_digital_ramp,
               row_select, row_index, row_valid, busy, frame_finished
    );

    modport slave (
        output start, continuous, expose_cycles, abort, row_ready,
        input  pixel_erase, pixel_expose, pixel_analog_ramp, pixel_digital_ramp,
               row_select, row_index, row_valid, busy, frame_finished
    );

endinterface

// File: rtl/frame_sequencer_phase_counter.sv
// Loadable down-counter timing the ERASE and EXPOSE phases.
module frame_sequencer_phase_counter
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned W = EXPOSE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] count_q;

    // Load a phase length minus one, then count down and park at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    // Last cycle of the current phase.
    assign done_c = (count_q == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one capture frame: erase, exposure, ramp conversion, row readout.
// reset is asynchronous and active-low.
module frame_sequencer
    import frame_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    frame_sequencer_if.master bus
);

    localparam logic [RAMP_BITS-1:0] RAMP_MAX   = '1;
    localparam logic [ROW_W-1:0]     ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [EXPOSE_W-1:0]  ERASE_LOAD = EXPOSE_W'(ERASE_CYCLES - 1);

    if (ERASE_CYCLES < 1 || ERASE_CYCLES > (2 ** EXPOSE_W) - 1) begin : g_bad_erase
        $error("ERASE_CYCLES does not fit the phase counter");
    end

    seq_state_t          state_q, state_d;
    seq_out_t            out_q, out_d;
    logic                pending_q, pending_d;
    logic [EXPOSE_W-1:0] exp_len_q, exp_len_d;
    logic                go_erase;
    logic                cnt_load;
    logic [EXPOSE_W-1:0] cnt_val;
    logic                cnt_done_c;

    frame_sequencer_phase_counter #(
        .W (EXPOSE_W)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done_c   (cnt_done_c)
    );

    // State, pending request, exposure length and all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            out_q     <= '0;
            pending_q <= 1'b0;
            exp_len_q <= EXPOSE_W'(1);
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            pending_q <= pending_d;
            exp_len_q <= exp_len_d;
        end
    end

    // Next state and next registered outputs; outputs default to zero.
    always_comb begin
        state_d   = state_q;
        out_d     = '0;
        exp_len_d = exp_len_q;
        go_erase  = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        pending_d = pending_q | (bus.start && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                go_erase = bus.start || pending_q;
            end
            S_ERASE: begin
                if (cnt_done_c) begin
                    state_d            = S_EXPOSE;
                    out_d.pixel_expose = 1'b1;
                    cnt_load           = 1'b1;
                    cnt_val            = exp_len_q - EXPOSE_W'(1);
                end else begin
                    out_d.pixel_erase = 1'b1;
                end
            end
            S_EXPOSE: begin
                if (cnt_done_c) begin
                    state_d                 = S_CONVERT;
                    out_d.pixel_analog_ramp = 1'b1;
                end else begin
                    out_d.pixel_expose = 1'b1;
                end
            end
            S_CONVERT: begin
                // Terminal count is compared explicitly rather than waiting for wrap.
                if (out_q.pixel_digital_ramp == RAMP_MAX) begin
                    state_d          = S_SETTLE;
                    out_d.row_index  = '0;
                    out_d.row_select = row_onehot('0);
                end else begin
                    out_d.pixel_analog_ramp  = 1'b1;
                    out_d.pixel_digital_ramp = out_q.pixel_digital_ramp + RAMP_BITS'(1);
                end
            end
            S_SETTLE: begin
                state_d          = S_READ;
                out_d.row_select = out_q.row_select;
                out_d.row_index  = out_q.row_index;
                out_d.row_valid  = 1'b1;
            end
            S_READ: begin
                if (out_q.row_valid && bus.row_ready) begin
                    if (out_q.row_index == ROW_LAST) begin
                        state_d              = S_DONE;
                        out_d.frame_finished = 1'b1;
                    end else begin
                        state_d          = S_SETTLE;
                        out_d.row_index  = out_q.row_index + ROW_W'(1);
                        out_d.row_select = row_onehot(out_q.row_index + ROW_W'(1));
                    end
                end else begin
                    out_d.row_select = out_q.row_select;
                    out_d.row_index  = out_q.row_index;
                    out_d.row_valid  = 1'b1;
                end
            end
            S_DONE: begin
                go_erase = bus.continuous || pending_q;
                if (!go_erase) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame start: latch the exposure length (zero means one) and time the erase.
        if (go_erase) begin
            state_d           = S_ERASE;
            out_d.pixel_erase = 1'b1;
            cnt_load          = 1'b1;
            cnt_val           = ERASE_LOAD;
            exp_len_d         = (bus.expose_cycles == '0) ? EXPOSE_W'(1) : bus.expose_cycles;
            pending_d         = 1'b0;
        end

        out_d.busy = (state_d != S_IDLE);

        // Abort outranks start, continuation and a same-cycle row handshake.
        if (bus.abort) begin
            state_d   = S_IDLE;
            out_d     = '0;
            pending_d = 1'b0;
            cnt_load  = 1'b0;
            exp_len_d = exp_len_q;
        end
    end

    assign bus.pixel_erase        = out_q.pixel_erase;
    assign bus.pixel_expose       = out_q.pixel_expose;
    assign bus.pixel_analog_ramp  = out_q.pixel_analog_ramp;
    assign bus.pixel_digital_ramp = out_q.pixel_digital_ramp;
    assign bus.row_select         = out_q.row_select;
    assign bus.row_index          = out_q.row_index;
    assign bus.row_valid          = out_q.row_valid;
    assign bus.busy               = out_q.busy;
    assign bus.frame_finished     = out_q.frame_finished;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer (ROWS=2, RAMP_BITS=8, ERASE_CYCLES=5).
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    frame_sequencer_if bus ();

    frame_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-frame observations gathered by run_frame.
    int n_cyc, n_erase, n_expose, n_analog, n_settle, n_valid, n_fin, ramp_bad, busy_bad;
    bit timed_out;
    logic [ROWS-1:0]  sel_seen [4];
    logic [ROW_W-1:0] idx_seen [4];
    bit ok;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.pixel_erase, bus.pixel_expose, bus.pixel_analog_ramp,
                    bus.pixel_digital_ramp, bus.row_select, bus.row_index,
                    bus.row_valid, bus.busy, bus.frame_finished});
    endfunction

    // Observe from the current cycle up to and including the FRAME_FINISHED cycle.
    task automatic run_frame(input bit pulse_in_convert, input bit chg_en,
                             input logic [EXPOSE_W-1:0] chg_val);
        logic [RAMP_BITS-1:0] ramp_exp;
        bit pulsed;
        bit changed;
        n_cyc = 0; n_erase = 0; n_expose = 0; n_analog = 0; n_settle = 0;
        n_valid = 0; n_fin = 0; ramp_bad = 0; busy_bad = 0; timed_out = 1'b0;
        ramp_exp = '0; pulsed = 1'b0; changed = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            n_cyc++;
            if (!bus.busy) busy_bad++;
            if (bus.pixel_erase) n_erase++;
            if (bus.pixel_expose) begin
                n_expose++;
                if (chg_en && !changed) begin
                    bus.expose_cycles = chg_val;
                    changed = 1'b1;
                end
            end
            if (bus.pixel_analog_ramp) begin
                n_analog++;
                if (bus.pixel_digital_ramp !== ramp_exp) ramp_bad++;
                ramp_exp = ramp_exp + 8'd1;
            end else if (bus.pixel_digital_ramp !== '0) begin
                ramp_bad++;
            end
            bus.start = 1'b0;
            if (pulse_in_convert && bus.pixel_analog_ramp && !pulsed) begin
                bus.start = 1'b1;
                pulsed = 1'b1;
            end
            if (bus.row_select != '0) begin
                if (bus.row_valid) begin
                    if (n_valid < 4) begin
                        sel_seen[n_valid] = bus.row_select;
                        idx_seen[n_valid] = bus.row_index;
                    end
                    n_valid++;
                end else begin
                    n_settle++;
                end
            end
            if (bus.frame_finished) begin
                n_fin++;
                return;
            end
            step();
        end
        timed_out = 1'b1;
    endtask

    task automatic wait_read(input logic [ROWS-1:0] sel, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.row_valid && bus.row_select == sel) begin
                hit = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic wait_convert(output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.pixel_analog_ramp) begin
                hit = 1'b1;
                return;
            end
            step();
        end
    endtask

    initial begin
        reset             = 1'b0;
        bus.start         = 1'b0;
        bus.continuous    = 1'b0;
        bus.expose_cycles = 16'd10;
        bus.abort         = 1'b0;
        bus.row_ready     = 1'b1;

        // Reset state
        step();
        step();
        check("reset_outs", all_outs(), 32'd0);
        reset = 1'b1;
        step();
        check("idle_after_reset", all_outs(), 32'd0);

        // Basic frame, exposure 10, ready tied high
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("first_cycle_erase", bus.pixel_erase, 1'b1);
        run_frame(1'b0, 1'b0, 16'd0);
        check("f1_timeout", timed_out, 1'b0);
        check("f1_cycles", n_cyc, 276);
        check("f1_erase", n_erase, 5);
        check("f1_expose", n_expose, 10);
        check("f1_analog", n_analog, 256);
        check("f1_ramp_seq", ramp_bad, 0);
        check("f1_busy", busy_bad, 0);
        check("f1_settle", n_settle, 2);
        check("f1_valid", n_valid, 2);
        check("f1_row0_sel", sel_seen[0], 2'b01);
        check("f1_row1_sel", sel_seen[1], 2'b10);
        check("f1_row1_idx", idx_seen[1], 1'b1);
        check("f1_done_sel", bus.row_select, 2'b00);
        step();
        check("f1_idle_busy", bus.busy, 1'b0);
        check("f1_fin_pulse", bus.frame_finished, 1'b0);

        // Stall row 0 for 7 cycles
        bus.row_ready = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_read(2'b01, ok);
        check("stall_reached", ok, 1'b1);
        begin
            int stable;
            stable = 0;
            for (int i = 0; i < 7; i++) begin
                step();
                if (bus.row_select == 2'b01 && bus.row_valid && bus.row_index == 1'b0 &&
                    !bus.frame_finished && bus.busy)
                    stable++;
            end
            check("stall_hold", stable, 7);
        end
        bus.row_ready = 1'b1;
        step();
        check("stall_settle1", {bus.row_select, bus.row_valid, bus.row_index}, {2'b10, 1'b0, 1'b1});
        step();
        check("stall_read1", {bus.row_select, bus.row_valid}, {2'b10, 1'b1});
        step();
        check("stall_done", {bus.frame_finished, bus.row_select}, {1'b1, 2'b00});
        step();
        check("stall_idle", bus.busy, 1'b0);

        // Zero exposure is one cycle
        bus.expose_cycles = 16'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_frame(1'b0, 1'b0, 16'd0);
        check("exp0_expose", n_expose, 1);
        check("exp0_cycles", n_cyc, 267);
        step();

        // Changing EXPOSE_CYCLES mid-exposure has no effect
        bus.expose_cycles = 16'd10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_frame(1'b0, 1'b1, 16'd3);
        check("expchg_expose", n_expose, 10);
        step();
        bus.expose_cycles = 16'd10;

        // START during CONVERT queues exactly one extra frame
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_frame(1'b1, 1'b0, 16'd0);
        check("pend_f1_fin", n_fin, 1);
        step();
        check("pend_restart_erase", bus.pixel_erase, 1'b1);
        run_frame(1'b0, 1'b0, 16'd0);
        check("pend_f2_cycles", n_cyc, 276);
        step();
        check("pend_idle", bus.busy, 1'b0);
        step();
        check("pend_no_third", bus.busy, 1'b0);

        // ABORT in READ row 1 with ROW_READY high
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_read(2'b10, ok);
        check("abort_reached", ok, 1'b1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_outs", all_outs(), 32'd0);
        step();
        check("abort_no_fin", {bus.frame_finished, bus.busy}, 2'b00);

        // Continuous capture for three frames
        bus.continuous = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_frame(1'b0, 1'b0, 16'd0);
        check("cont_f1_fin", n_fin, 1);
        step();
        check("cont_f2_erase", bus.pixel_erase, 1'b1);
        run_frame(1'b0, 1'b0, 16'd0);
        check("cont_f2_fin", n_fin, 1);
        step();
        check("cont_f3_erase", bus.pixel_erase, 1'b1);
        repeat (10) step();
        bus.continuous = 1'b0;
        run_frame(1'b0, 1'b0, 16'd0);
        check("cont_f3_fin", n_fin, 1);
        check("cont_f3_cycles", n_cyc, 266);
        step();
        check("cont_idle", bus.busy, 1'b0);

        // Asynchronous reset mid-CONVERT
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_convert(ok);
        check("rst_conv_reached", ok, 1'b1);
        repeat (20) step();
        check("rst_mid_ramp", bus.pixel_digital_ramp, 8'd20);
        #1 reset = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 32'd0);
        #2 reset = 1'b1;
        step();
        check("rst_stays_idle", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
